// File: rtl/id_exe_skid_pkg.sv
// Shared constants for the ID->EXE pipeline register.
// Bubble encodings and default widths used by id_exe_skid.
package id_exe_skid_pkg;

    localparam int RDATA_WIDTH    = 32;
    localparam int RADDR_WIDTH    = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int PIPE_CNT_WIDTH = 16;

    // addi x0, x0, 0
    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam logic [31:0] ZERO          = 32'h0000_0000;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [4:0]  ZERO_REG      = 5'd0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready handshake and flush.
// Ports: clk_i, rst_i, flush_i, in_valid_i/in_ready_o/in_data_i,
//        out_valid_o/out_ready_i/out_data_o.
module pipe_skid_buf #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         acc;
    logic         deq;

    // Ready depends only on stored state, so no comb path from out_ready_i.
    assign in_ready_o  = ~skid_valid;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;

    assign acc = in_valid_i & ~skid_valid;
    assign deq = main_valid & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RST_VAL;
            skid_data  <= RST_VAL;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (deq) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || deq) begin
            main_valid <= acc;
            if (acc) begin
                main_data <= in_data_i;
            end
        end else if (acc) begin
            skid_data  <= in_data_i;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/id_exe_skid.sv
// ID->EXE pipeline register with skid buffer, flush, NOP bubbles
// and a saturating stall counter. Ports: see handshake/payload below.
module id_exe_skid
    import id_exe_skid_pkg::*;
#(
    parameter int RDATA_W = RDATA_WIDTH,
    parameter int RADDR_W = RADDR_WIDTH,
    parameter int INST_W  = DATA_WIDTH,
    parameter int CNT_W   = PIPE_CNT_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [RDATA_W-1:0] op1_i,
    input  logic [RDATA_W-1:0] op2_i,
    input  logic               reg_we_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic [INST_W-1:0]  inst_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [RDATA_W-1:0] op1_o,
    output logic [RDATA_W-1:0] op2_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [INST_W-1:0]  inst_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam int PW = INST_W + 2 * RDATA_W + 1 + RADDR_W;

    localparam logic [INST_W-1:0]  B_INST = INST_W'(NOP);
    localparam logic [RDATA_W-1:0] B_OP   = RDATA_W'(ZERO);
    localparam logic [RADDR_W-1:0] B_WA   = RADDR_W'(ZERO_REG);
    localparam logic [PW-1:0]      B_PL   =
        {B_INST, B_OP, B_OP, WRITE_DISABLE, B_WA};

    logic [PW-1:0]      in_pl;
    logic [PW-1:0]      out_pl;
    logic               valid;
    logic [INST_W-1:0]  s_inst;
    logic [RDATA_W-1:0] s_op1;
    logic [RDATA_W-1:0] s_op2;
    logic               s_we;
    logic [RADDR_W-1:0] s_wa;
    logic [CNT_W-1:0]   cnt;

    assign in_pl = {inst_i, op1_i, op2_i, reg_we_i, reg_waddr_i};

    pipe_skid_buf #(
        .W       (PW),
        .RST_VAL (B_PL)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_pl),
        .out_valid_o (valid),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_pl)
    );

    assign {s_inst, s_op1, s_op2, s_we, s_wa} = out_pl;

    // Stale payload may linger after flush; mask it with a bubble.
    assign out_valid_o = valid;
    assign inst_o      = valid ? s_inst : B_INST;
    assign op1_o       = valid ? s_op1  : B_OP;
    assign op2_o       = valid ? s_op2  : B_OP;
    assign reg_we_o    = valid ? s_we   : WRITE_DISABLE;
    assign reg_waddr_o = valid ? s_wa   : B_WA;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (valid && !out_ready_i && !(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_id_exe_skid.sv
// Self-checking bench for id_exe_skid: queue model, directed and
// random stimulus; a 4-bit counter instance checks saturation.
module tb_id_exe_skid;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        we;
        logic [4:0]  wa;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic [31:0] inst_i = '0;

    logic        in_ready_o, out_valid_o, reg_we_o;
    logic [31:0] op1_o, op2_o, inst_o;
    logic [4:0]  reg_waddr_o;
    logic [15:0] stall_cnt_o;

    logic        in_ready4, out_valid4, reg_we4;
    logic [31:0] op1_4, op2_4, inst_4;
    logic [4:0]  waddr4;
    logic [3:0]  stall4;

    int pass_cnt = 0;
    int total = 0;

    pl_t         q[$];
    int unsigned m_cnt = 0;
    int unsigned m_cnt4 = 0;

    always #5 clk = ~clk;

    id_exe_skid dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_we_i    (reg_we_i),
        .reg_waddr_i (reg_waddr_i),
        .inst_i      (inst_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .inst_o      (inst_o),
        .stall_cnt_o (stall_cnt_o)
    );

    id_exe_skid #(.CNT_W(4)) dut4 (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready4),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_we_i    (reg_we_i),
        .reg_waddr_i (reg_waddr_i),
        .inst_i      (inst_i),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready_i),
        .op1_o       (op1_4),
        .op2_o       (op2_4),
        .reg_we_o    (reg_we4),
        .reg_waddr_o (waddr4),
        .inst_o      (inst_4),
        .stall_cnt_o (stall4)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Model: the stage is a 2-deep FIFO; head is shown, else a bubble.
    task automatic model_update();
        pl_t p;
        bit  ov;
        bit  acc;
        if (rst_i) begin
            q.delete();
            m_cnt  = 0;
            m_cnt4 = 0;
        end else begin
            ov = (q.size() > 0);
            if (ov && !out_ready_i) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush_i) begin
                q.delete();
            end else begin
                acc = in_valid_i && (q.size() < 2);
                if (ov && out_ready_i) void'(q.pop_front());
                if (acc) begin
                    p = '{inst_i, op1_i, op2_i, reg_we_i, reg_waddr_i};
                    q.push_back(p);
                end
            end
        end
    endtask

    task automatic check_all();
        pl_t e;
        e = '{32'h0000_0013, 32'h0, 32'h0, 1'b0, 5'd0};
        if (q.size() > 0) e = q[0];
        chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready_o), 64'(q.size() < 2));
        chk("inst", 64'(inst_o), 64'(e.inst));
        chk("op1", 64'(op1_o), 64'(e.op1));
        chk("op2", 64'(op2_o), 64'(e.op2));
        chk("reg_we", 64'(reg_we_o), 64'(e.we));
        chk("waddr", 64'(reg_waddr_o), 64'(e.wa));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
        chk("stall_cnt4", 64'(stall4), 64'(m_cnt4));
        chk("out_valid4", 64'(out_valid4), 64'(q.size() > 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa);
        in_valid_i  = v;
        inst_i      = ins;
        op1_i       = a;
        op2_i       = b;
        reg_we_i    = v;
        reg_waddr_i = wa;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset held 2 cycles with an instruction presented.
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, 32'h0050_0093, 32'd5, 32'd0, 5'd1);
        step();
        step();
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'h13);
        chk("rst_we", 64'(reg_we_o), 64'd0);
        chk("rst_stall", 64'(stall_cnt_o), 64'd0);
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);

        // Streaming A, B, C.
        do_reset();
        out_ready_i = 1'b1;
        drive(1'b1, 32'h0010_0093, 32'd1, 32'd1, 5'd1);
        step();
        chk("str_A", 64'(inst_o), 64'h0010_0093);
        drive(1'b1, 32'h0020_0113, 32'd2, 32'd2, 5'd2);
        step();
        chk("str_B", 64'(inst_o), 64'h0020_0113);
        chk("str_B_wa", 64'(reg_waddr_o), 64'd2);
        drive(1'b1, 32'h0030_0193, 32'd3, 32'd3, 5'd3);
        step();
        chk("str_C", 64'(inst_o), 64'h0030_0193);
        chk("str_C_op1", 64'(op1_o), 64'd3);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        step();
        chk("str_end", 64'(out_valid_o), 64'd0);

        // Backpressure.
        do_reset();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'd1, 32'd1, 5'd1);
        step();
        drive(1'b1, 32'h0020_0113, 32'd2, 32'd2, 5'd2);
        step();
        chk("bp_ready0", 64'(in_ready_o), 64'd0);
        drive(1'b1, 32'h0030_0193, 32'd3, 32'd3, 5'd3);
        step();
        chk("bp_holdA", 64'(inst_o), 64'h0010_0093);
        chk("bp_stall", 64'(stall_cnt_o), 64'd2);
        out_ready_i = 1'b1;
        step();
        chk("bp_B", 64'(inst_o), 64'h0020_0113);
        step();
        chk("bp_C", 64'(inst_o), 64'h0030_0193);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        step();
        chk("bp_empty", 64'(out_valid_o), 64'd0);
        chk("bp_stall2", 64'(stall_cnt_o), 64'd2);

        // Flush with full buffer and a new input.
        do_reset();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'd1, 32'd1, 5'd1);
        step();
        drive(1'b1, 32'h0020_0113, 32'd2, 32'd2, 5'd2);
        step();
        flush_i = 1'b1;
        drive(1'b1, 32'h0040_0213, 32'd4, 32'd4, 5'd4);
        step();
        chk("fl_valid", 64'(out_valid_o), 64'd0);
        chk("fl_inst", 64'(inst_o), 64'h13);
        chk("fl_ready", 64'(in_ready_o), 64'd1);
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        step();
        chk("fl_noD", 64'(out_valid_o), 64'd0);

        // Simultaneous acc and deq.
        do_reset();
        out_ready_i = 1'b1;
        drive(1'b1, 32'h0010_0093, 32'd1, 32'd1, 5'd1);
        step();
        drive(1'b1, 32'h0020_0113, 32'd2, 32'd2, 5'd2);
        step();
        chk("sim_B", 64'(inst_o), 64'h0020_0113);
        chk("sim_ready", 64'(in_ready_o), 64'd1);

        // Saturation: 20 stalled cycles.
        do_reset();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'd1, 32'd1, 5'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 20; i++) step();
        chk("sat4", 64'(stall4), 64'd15);
        chk("sat16", 64'(stall_cnt_o), 64'd20);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_i       = ($urandom_range(0, 299) == 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            out_ready_i = ($urandom_range(0, 9) < 6);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            inst_i      = $urandom;
            op1_i       = $urandom;
            op2_i       = $urandom;
            reg_we_i    = $urandom_range(0, 1);
            reg_waddr_i = 5'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
